// File: rtl/cp0_int_ctrl_pkg.sv
// Shared CP0 definitions: Cause.IP bit layout, timer IP default,
// CP0 register numbers used by the MTC0/MFC0 decoder, and the
// Cause.IP composition helper.
package cp0_int_ctrl_pkg;

    // Cause.IP bit positions
    localparam int unsigned IP_SW0 = 0;
    localparam int unsigned IP_SW1 = 1;
    localparam int unsigned IP_HW0 = 2;
    localparam int unsigned IP_HW1 = 3;
    localparam int unsigned IP_HW2 = 4;
    localparam int unsigned IP_HW3 = 5;
    localparam int unsigned IP_HW4 = 6;
    localparam int unsigned IP_HW5 = 7;

    // Cause.IP bit that carries the timer interrupt by default
    localparam int unsigned TIMER_IP_DEFAULT = IP_HW5;

    // CP0 register numbers owned by the interrupt controller
    typedef logic [4:0] cp0_reg_t;
    localparam cp0_reg_t CP0_REG_COUNT   = 5'd9;
    localparam cp0_reg_t CP0_REG_COMPARE = 5'd11;
    localparam cp0_reg_t CP0_REG_CAUSE   = 5'd13;

    // Cause.IP = {hw_ip, sw_ip} with the timer pending bit ORed into timer_ip
    function automatic logic [7:0] cause_compose(input logic [1:0]  sw,
                                                 input logic [5:0]  hw,
                                                 input logic        tp,
                                                 input int unsigned timer_ip);
        logic [7:0] ip;
        ip = {hw, sw};
        ip = ip | (8'(tp) << timer_ip);
        return ip;
    endfunction

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// CP0 <-> interrupt controller signal bundle. The master side is the
// CP0 register file / status logic, the slave side is cp0_int_ctrl.
interface cp0_int_ctrl_if;

    logic [5:0]  hw_int_in;
    logic        sw_ip_we;
    logic [1:0]  sw_ip_wdata;
    logic        count_we;
    logic [31:0] count_wdata;
    logic        compare_we;
    logic [31:0] compare_wdata;
    logic [7:0]  status_im;
    logic        status_ie;
    logic        status_exl;
    logic        status_erl;
    logic        int_taken;

    logic [31:0] count_out;
    logic [31:0] compare_out;
    logic [7:0]  cause_ip;
    logic        timer_pending;
    logic [7:0]  interrupt_flags;
    logic        allow_int;

    modport master (
        output hw_int_in, sw_ip_we, sw_ip_wdata, count_we, count_wdata,
               compare_we, compare_wdata, status_im, status_ie,
               status_exl, status_erl, int_taken,
        input  count_out, compare_out, cause_ip, timer_pending,
               interrupt_flags, allow_int
    );

    modport slave (
        input  hw_int_in, sw_ip_we, sw_ip_wdata, count_we, count_wdata,
               compare_we, compare_wdata, status_im, status_ie,
               status_exl, status_erl, int_taken,
        output count_out, compare_out, cause_ip, timer_pending,
               interrupt_flags, allow_int
    );

endinterface

// File: rtl/cp0_int_ctrl_int_sync_bit.sv
// Single-bit multi-flop synchroniser for an asynchronous level input.
// STAGES must be at least 2.
module int_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // shift the raw level one flop deeper each cycle
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // synchroniser flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt source controller: hardware interrupt synchronisers,
// Count/Compare timer, Cause.IP software bits, and the registered
// interrupt_flags / allow_int qualifiers for the MM-stage exception unit.
module cp0_int_ctrl
    import cp0_int_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COUNT_DIV   = 2,
    parameter int unsigned TIMER_IP    = TIMER_IP_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    cp0_int_ctrl_if.slave bus
);

    localparam logic [3:0] PRESC_LAST = 4'(COUNT_DIV - 1);

    logic [5:0]  hw_ip;

    logic [3:0]  presc_q,   presc_d;
    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic [1:0]  sw_ip_q,   sw_ip_d;
    logic        eq_q,      eq_d;
    logic        tp_q,      tp_d;
    logic        holdoff_q, holdoff_d;
    logic [7:0]  flags_q,   flags_d;
    logic        allow_q,   allow_d;
    logic        inc;
    logic [7:0]  cause;

    for (genvar g = 0; g < 6; g++) begin : g_sync
        int_sync_bit #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk_i (clk),
            .rst_i (rst),
            .d_i   (bus.hw_int_in[g]),
            .q_o   (hw_ip[g])
        );
    end

    // next-state for timer, software IP bits, holdoff and output qualifiers
    always_comb begin
        inc     = (presc_q == PRESC_LAST);
        count_d = count_q;
        presc_d = presc_q + 4'd1;
        if (bus.count_we) begin
            count_d = bus.count_wdata;
            presc_d = '0;
        end else if (inc) begin
            count_d = count_q + 32'd1;
            presc_d = '0;
        end

        compare_d = bus.compare_we ? bus.compare_wdata : compare_q;

        // Match is flagged only when Count actually changes, against the old
        // Compare; the pending set lands one cycle later. A Compare write in
        // either cycle suppresses the set so the clear always wins.
        eq_d = (bus.count_we | inc) & (count_d == compare_q) & ~bus.compare_we;
        tp_d = bus.compare_we ? 1'b0 : (tp_q | eq_q);

        sw_ip_d   = bus.sw_ip_we ? bus.sw_ip_wdata : sw_ip_q;
        holdoff_d = bus.int_taken;

        cause   = cause_compose(sw_ip_q, hw_ip, tp_q, TIMER_IP);
        flags_d = cause & bus.status_im;
        allow_d = bus.status_ie & ~bus.status_exl & ~bus.status_erl & ~holdoff_q;
    end

    // controller state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            sw_ip_q   <= '0;
            eq_q      <= 1'b0;
            tp_q      <= 1'b0;
            holdoff_q <= 1'b0;
            flags_q   <= '0;
            allow_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            sw_ip_q   <= sw_ip_d;
            eq_q      <= eq_d;
            tp_q      <= tp_d;
            holdoff_q <= holdoff_d;
            flags_q   <= flags_d;
            allow_q   <= allow_d;
        end
    end

    assign bus.count_out       = count_q;
    assign bus.compare_out     = compare_q;
    assign bus.cause_ip        = cause;
    assign bus.timer_pending   = tp_q;
    assign bus.interrupt_flags = flags_q;
    assign bus.allow_int       = allow_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed + randomized bench for cp0_int_ctrl with a history-based
// reference model of the interrupt controller.
module tb_cp0_int_ctrl;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DIV  = 2;
    localparam int unsigned TIP  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cp0_int_ctrl_if bus ();

    cp0_int_ctrl #(
        .SYNC_STAGES (SYNC),
        .COUNT_DIV   (DIV),
        .TIMER_IP    (TIP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [5:0]  m_hist[$];
    logic [31:0] m_base;
    int unsigned m_since;
    logic [31:0] m_cmp;
    logic        m_tp;
    logic        m_pend;
    logic [1:0]  m_sw;
    logic        m_taken_prev;
    logic [7:0]  m_flags;
    logic        m_allow;

    function automatic logic [5:0] m_hw();
        if (m_hist.size() >= SYNC) return m_hist[m_hist.size() - SYNC];
        return 6'h00;
    endfunction

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_since / DIV);
    endfunction

    function automatic logic [7:0] m_cause();
        logic [7:0] c;
        c = {m_hw(), m_sw};
        if (m_tp) c[TIP] = 1'b1;
        return c;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_base = '0; m_since = 0; m_cmp = '0; m_tp = 1'b0; m_pend = 1'b0;
        m_sw = '0; m_taken_prev = 1'b0; m_flags = '0; m_allow = 1'b0;
    endtask

    // advance the model across one rising edge using the inputs held at it
    task automatic model_edge();
        logic ev;
        m_flags = m_cause() & bus.status_im;
        m_allow = bus.status_ie & ~bus.status_exl & ~bus.status_erl & ~m_taken_prev;
        m_taken_prev = bus.int_taken;
        m_tp = bus.compare_we ? 1'b0 : (m_tp | m_pend);
        if (bus.count_we) begin
            m_base = bus.count_wdata; m_since = 0; ev = 1'b1;
        end else begin
            m_since++; ev = ((m_since % DIV) == 0);
        end
        m_pend = ev && (m_count() == m_cmp) && !bus.compare_we;
        if (bus.compare_we) m_cmp = bus.compare_wdata;
        if (bus.sw_ip_we) m_sw = bus.sw_ip_wdata;
        m_hist.push_back(bus.hw_int_in);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count",   bus.count_out,              m_count());
        chk("compare", bus.compare_out,            m_cmp);
        chk("cause",   32'(bus.cause_ip),          32'(m_cause()));
        chk("tp",      32'(bus.timer_pending),     32'(m_tp));
        chk("flags",   32'(bus.interrupt_flags),   32'(m_flags));
        chk("allow",   32'(bus.allow_int),         32'(m_allow));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic cmp_write(input logic [31:0] v);
        bus.compare_we = 1'b1; bus.compare_wdata = v;
        step();
        bus.compare_we = 1'b0;
    endtask

    task automatic cnt_write(input logic [31:0] v);
        bus.count_we = 1'b1; bus.count_wdata = v;
        step();
        bus.count_we = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_count"}, bus.count_out, 32'h0);
        chk({tag, "_cause"}, 32'(bus.cause_ip), 32'h0);
        chk({tag, "_tp"},    32'(bus.timer_pending), 32'h0);
        chk({tag, "_flags"}, 32'(bus.interrupt_flags), 32'h0);
        chk({tag, "_allow"}, 32'(bus.allow_int), 32'h0);
    endtask

    initial begin
        bus.hw_int_in = '0; bus.sw_ip_we = 1'b0; bus.sw_ip_wdata = '0;
        bus.count_we = 1'b0; bus.count_wdata = '0;
        bus.compare_we = 1'b0; bus.compare_wdata = '0;
        bus.status_im = '0; bus.status_ie = 1'b0;
        bus.status_exl = 1'b0; bus.status_erl = 1'b0; bus.int_taken = 1'b0;
        model_reset();

        // reset held, then released
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        @(negedge clk);
        rst = 1'b0;
        step();
        bus.status_ie = 1'b1;
        step();
        chk("allow_after_ie", 32'(bus.allow_int), 32'h1);

        // hardware line 0 through the synchroniser
        bus.hw_int_in = 6'h01; bus.status_im = 8'h04;
        step();
        chk("hw_lat1", 32'(bus.cause_ip), 32'h00);
        step();
        chk("hw_lat2", 32'(bus.cause_ip), 32'h04);
        chk("hw_flags_lag", 32'(bus.interrupt_flags), 32'h00);
        step();
        chk("hw_flags", 32'(bus.interrupt_flags), 32'h04);
        bus.status_im = 8'h00;
        step();
        chk("hw_masked_flags", 32'(bus.interrupt_flags), 32'h00);
        chk("hw_masked_cause", 32'(bus.cause_ip), 32'h04);
        bus.hw_int_in = 6'h00;
        repeat (3) step();

        // Count/Compare match
        cmp_write(32'h10);
        cnt_write(32'h0E);
        repeat (4) step();
        chk("cnt_reach", bus.count_out, 32'h10);
        chk("tp_not_yet", 32'(bus.timer_pending), 32'h0);
        step();
        chk("tp_set", 32'(bus.timer_pending), 32'h1);
        chk("tp_cause7", 32'(bus.cause_ip[7]), 32'h1);
        cmp_write(32'h20);
        chk("tp_clear", 32'(bus.timer_pending), 32'h0);

        // wrap to zero with compare 0
        cmp_write(32'h0);
        cnt_write(32'hFFFF_FFFF);
        repeat (DIV) step();
        chk("wrap_cnt", bus.count_out, 32'h0);
        step();
        chk("wrap_tp", 32'(bus.timer_pending), 32'h1);
        cmp_write(32'h0);
        cnt_write(32'hFFFF_FFFF);
        step();
        cmp_write(32'h5);
        chk("clr_win_cnt", bus.count_out, 32'h0);
        step();
        chk("clr_win_tp1", 32'(bus.timer_pending), 32'h0);
        step();
        chk("clr_win_tp2", 32'(bus.timer_pending), 32'h0);

        // software IP and holdoff
        bus.status_im = 8'h02; bus.status_ie = 1'b1; bus.status_exl = 1'b0;
        bus.sw_ip_we = 1'b1; bus.sw_ip_wdata = 2'h2;
        step();
        bus.sw_ip_we = 1'b0;
        step();
        chk("sw_flags", 32'(bus.interrupt_flags), 32'h02);
        bus.int_taken = 1'b1;
        step();
        bus.int_taken = 1'b0;
        chk("hold_t0", 32'(bus.allow_int), 32'h1);
        step();
        chk("hold_t1", 32'(bus.allow_int), 32'h0);
        step();
        chk("hold_t2", 32'(bus.allow_int), 32'h1);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bus.hw_int_in   = 6'($urandom);
            bus.sw_ip_we    = ($urandom_range(0, 7) == 0);
            bus.sw_ip_wdata = 2'($urandom);
            bus.status_im   = 8'($urandom);
            bus.status_ie   = ($urandom_range(0, 3) != 0);
            bus.status_exl  = ($urandom_range(0, 5) == 0);
            bus.status_erl  = ($urandom_range(0, 9) == 0);
            bus.int_taken   = ($urandom_range(0, 9) == 0);
            bus.compare_we  = ($urandom_range(0, 15) == 0);
            bus.compare_wdata = m_count() + 32'($urandom_range(0, 6));
            bus.count_we    = ($urandom_range(0, 15) == 0);
            bus.count_wdata = ($urandom_range(0, 1) == 0) ? m_cmp - 32'($urandom_range(0, 3))
                                                          : 32'($urandom);
            step();
        end
        bus.sw_ip_we = 1'b0; bus.compare_we = 1'b0; bus.count_we = 1'b0;
        bus.int_taken = 1'b0;

        // reset mid-operation
        cmp_write(32'h1234);
        cnt_write(32'h1234);
        step();
        chk("mid_cnt", bus.count_out, 32'h1234);
        chk("mid_tp", 32'(bus.timer_pending), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        chk("mid_rst_cmp", bus.compare_out, 32'h0);
        model_reset();
        bus.hw_int_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("restart0", bus.count_out, 32'h0);
        step();
        chk("restart1", bus.count_out, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
